// File: rtl/dma_rx_word_packer.sv
// dma_rx_word_packer
// Drains the 32-bit DMA RX FIFO and packs words into OUT_WORDS-wide beats
// on a valid/ready stream toward the RX write engine. Partial beats are
// emitted on an explicit flush request or after an idle timeout, carrying
// a lane-keep mask and a last flag.
//
// Ports:
//   user_clk       clock
//   reset_n        asynchronous active-low reset
//   enable         permits FIFO pops
//   flush_req      pulse: emit the partial accumulator
//   flush_done     one-cycle pulse when a flush has completed
//   fifo_re        FIFO pop (combinational)
//   fifo_rd        FIFO head word, consumed in the pop cycle
//   fifo_used_cnt  FIFO occupancy
//   m_valid/m_ready/m_data/m_keep/m_last  output beat stream
//   beat_cnt       accepted beats, wraps
module dma_rx_word_packer #(
    parameter int OUT_WORDS     = 4,
    parameter int FLUSH_TIMEOUT = 256
) (
    input  logic                   user_clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   flush_req,
    output logic                   flush_done,
    output logic                   fifo_re,
    input  logic [31:0]            fifo_rd,
    input  logic [10:0]            fifo_used_cnt,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [32*OUT_WORDS-1:0] m_data,
    output logic [OUT_WORDS-1:0]   m_keep,
    output logic                   m_last,
    output logic [31:0]            beat_cnt
);

    localparam int CW = $clog2(OUT_WORDS) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(OUT_WORDS);
    localparam logic [15:0]   TIMEOUT  = 16'(FLUSH_TIMEOUT);

    // Registered state
    logic                    run_reg;
    logic [32*OUT_WORDS-1:0] acc_data_reg;
    logic [CW-1:0]           acc_cnt_reg;
    logic [15:0]             idle_reg;
    logic                    flush_pend_reg;
    logic                    flush_done_reg;
    logic                    m_valid_reg;
    logic [32*OUT_WORDS-1:0] m_data_reg;
    logic [OUT_WORDS-1:0]    m_keep_reg;
    logic                    m_last_reg;
    logic [31:0]             beat_cnt_reg;

    // Combinational control
    logic                    out_free;
    logic                    flush_hold;
    logic                    acc_full;
    logic                    acc_nonempty;
    logic                    timeout_hit;
    logic                    flush_move;
    logic                    full_move;
    logic                    move;
    logic                    pop;
    logic                    flush_complete;
    logic [CW-2:0]           wr_lane;
    logic [OUT_WORDS-1:0]    lane_keep;
    logic [32*OUT_WORDS-1:0] lane_data;
    logic [32*OUT_WORDS-1:0] acc_data_next;
    logic [CW-1:0]           acc_cnt_next;
    logic [15:0]             idle_next;

    assign out_free     = ~m_valid_reg | m_ready;
    // A request blocks pops in its own cycle too, so nothing slips into the
    // accumulator between the request and the flush beat.
    assign flush_hold   = flush_pend_reg | flush_req;
    assign acc_full     = (acc_cnt_reg == FULL_CNT);
    assign acc_nonempty = (acc_cnt_reg != '0);
    // idle_reg saturates at TIMEOUT, so equality is a sticky condition.
    assign timeout_hit  = (idle_reg == TIMEOUT);
    assign flush_move   = out_free & acc_nonempty & (flush_hold | timeout_hit);
    assign full_move    = out_free & acc_full;
    assign move         = flush_move | full_move;
    // run_reg keeps fifo_re low while reset is (or has just been) asserted.
    assign pop          = run_reg & enable & ~flush_hold & (fifo_used_cnt != 11'd0)
                          & (~acc_full | move);
    // Flush is finished once the accumulator is empty and the output
    // register is empty or being accepted this cycle.
    assign flush_complete = flush_hold & ~acc_nonempty & out_free;

    assign wr_lane = move ? '0 : acc_cnt_reg[CW-2:0];

    generate
        for (genvar gi = 0; gi < OUT_WORDS; gi++) begin : g_lane
            assign lane_keep[gi] = (CW'(gi) < acc_cnt_reg);
            // Lanes beyond the fill level go out as zero.
            assign lane_data[gi*32 +: 32] = lane_keep[gi] ? acc_data_reg[gi*32 +: 32] : 32'd0;
            assign acc_data_next[gi*32 +: 32] = (pop && (wr_lane == (CW-1)'(gi)))
                                                ? fifo_rd : acc_data_reg[gi*32 +: 32];
        end
    endgenerate

    always_comb begin
        acc_cnt_next = acc_cnt_reg;
        if (move && pop) begin
            acc_cnt_next = CW'(1);
        end else if (move) begin
            acc_cnt_next = '0;
        end else if (pop) begin
            acc_cnt_next = acc_cnt_reg + CW'(1);
        end
    end

    always_comb begin
        idle_next = idle_reg;
        if (pop || move || !acc_nonempty) begin
            idle_next = 16'd0;
        end else if (!timeout_hit) begin
            idle_next = idle_reg + 16'd1;
        end
    end

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            run_reg        <= 1'b0;
            acc_data_reg   <= '0;
            acc_cnt_reg    <= '0;
            idle_reg       <= 16'd0;
            flush_pend_reg <= 1'b0;
            flush_done_reg <= 1'b0;
            m_valid_reg    <= 1'b0;
            m_data_reg     <= '0;
            m_keep_reg     <= '0;
            m_last_reg     <= 1'b0;
            beat_cnt_reg   <= 32'd0;
        end else begin
            run_reg        <= 1'b1;
            acc_data_reg   <= acc_data_next;
            acc_cnt_reg    <= acc_cnt_next;
            idle_reg       <= idle_next;
            flush_done_reg <= flush_complete;
            if (flush_complete) begin
                flush_pend_reg <= 1'b0;
            end else if (flush_req) begin
                flush_pend_reg <= 1'b1;
            end
            if (move) begin
                m_valid_reg <= 1'b1;
                m_data_reg  <= lane_data;
                m_keep_reg  <= lane_keep;
                m_last_reg  <= flush_move;
            end else if (m_ready) begin
                m_valid_reg <= 1'b0;
            end
            if (m_valid_reg && m_ready) begin
                beat_cnt_reg <= beat_cnt_reg + 32'd1;
            end
        end
    end

    assign fifo_re    = pop;
    assign flush_done = flush_done_reg;
    assign m_valid    = m_valid_reg;
    assign m_data     = m_data_reg;
    assign m_keep     = m_keep_reg;
    assign m_last     = m_last_reg;
    assign beat_cnt   = beat_cnt_reg;

endmodule

// File: tb/tb_dma_rx_word_packer.sv
module tb_dma_rx_word_packer;

    logic         user_clk = 1'b0;
    logic         reset_n;
    logic         enable;
    logic         flush_req;
    logic         flush_done;
    logic         fifo_re;
    logic [31:0]  fifo_rd;
    logic [10:0]  fifo_used_cnt;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic [3:0]   m_keep;
    logic         m_last;
    logic [31:0]  beat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    dma_rx_word_packer #(.OUT_WORDS(4), .FLUSH_TIMEOUT(16)) dut (
        .user_clk      (user_clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .flush_req     (flush_req),
        .flush_done    (flush_done),
        .fifo_re       (fifo_re),
        .fifo_rd       (fifo_rd),
        .fifo_used_cnt (fifo_used_cnt),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_keep        (m_keep),
        .m_last        (m_last),
        .beat_cnt      (beat_cnt)
    );

    always #5 user_clk = ~user_clk;

    // FIFO model: words pushed by the stimulus, popped on fifo_re
    logic [31:0] fmem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_used_cnt = 11'(wr_ptr - rd_ptr);
    assign fifo_rd       = fmem[rd_ptr[7:0]];

    // Monitor: records accepted beats, pops and flush_done pulses
    logic [127:0] cap_data [0:63];
    logic [3:0]   cap_keep [0:63];
    logic         cap_last [0:63];
    int           cap_cyc  [0:63];
    int cap_n     = 0;
    int cyc       = 0;
    int pop_total = 0;
    int fd_cnt    = 0;
    int fd_cyc    = -1;
    logic re_empty = 1'b0;

    always @(posedge user_clk) begin
        cyc <= cyc + 1;
        if (reset_n) begin
            if (m_valid && m_ready && cap_n < 64) begin
                cap_data[cap_n] <= m_data;
                cap_keep[cap_n] <= m_keep;
                cap_last[cap_n] <= m_last;
                cap_cyc[cap_n]  <= cyc;
                cap_n           <= cap_n + 1;
            end
            if (fifo_re) begin
                pop_total <= pop_total + 1;
                rd_ptr    <= rd_ptr + 1;
                if (fifo_used_cnt == 11'd0) re_empty <= 1'b1;
            end
            if (flush_done) begin
                fd_cnt <= fd_cnt + 1;
                fd_cyc <= cyc;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge user_clk);
    endtask

    task automatic push_word(input logic [31:0] w);
        fmem[wr_ptr[7:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        @(negedge user_clk);
        enable    = 1'b0;
        flush_req = 1'b0;
        m_ready   = 1'b0;
        reset_n   = 1'b0;
        @(negedge user_clk);
        wr_ptr  = rd_ptr;
        reset_n = 1'b1;
        cycles(2);
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({m_valid, m_keep, m_last, fifo_re, flush_done} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 00000000", {m_valid, m_keep, m_last, fifo_re, flush_done});
        end
        n_checks++;
        if (m_data !== 128'd0 || beat_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: m_data=%h beat_cnt=%0d required 0/0", m_data, beat_cnt);
        end
        @(negedge user_clk);
        reset_n = 1'b1;
        cycles(2);
        $display("test_reset done");
    endtask

    task automatic test_stream();
        int base, run, maxrun, ones;
        logic [127:0] exp0, exp1;
        do_reset();
        base = cap_n;
        for (int i = 0; i < 8; i++) push_word(32'(i));
        m_ready = 1'b1;
        enable  = 1'b1;
        run = 0; maxrun = 0; ones = 0;
        for (int k = 0; k < 14; k++) begin
            #1;
            if (fifo_re) begin run++; ones++; end else run = 0;
            if (run > maxrun) maxrun = run;
            @(negedge user_clk);
        end
        cycles(4);
        n_checks++;
        if (maxrun != 8 || ones != 8) begin
            n_fail++;
            $display("FAIL stream_pops: run=%0d total=%0d required 8/8", maxrun, ones);
        end
        exp0 = 128'h00000003_00000002_00000001_00000000;
        exp1 = 128'h00000007_00000006_00000005_00000004;
        n_checks++;
        if (cap_n - base != 2) begin
            n_fail++;
            $display("FAIL stream_beats: got %0d required 2", cap_n - base);
        end else begin
            n_checks++;
            if (cap_data[base] !== exp0 || cap_data[base+1] !== exp1) begin
                n_fail++;
                $display("FAIL stream_data: got %h %h required %h %h", cap_data[base], cap_data[base+1], exp0, exp1);
            end
            n_checks++;
            if (cap_keep[base] !== 4'hF || cap_keep[base+1] !== 4'hF || cap_last[base] !== 1'b0 || cap_last[base+1] !== 1'b0) begin
                n_fail++;
                $display("FAIL stream_keep_last: keep %h %h last %b %b required F F 0 0",
                         cap_keep[base], cap_keep[base+1], cap_last[base], cap_last[base+1]);
            end
        end
        n_checks++;
        if (beat_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL stream_beat_cnt: got %0d required 2", beat_cnt);
        end
        $display("test_stream done");
    endtask

    task automatic test_backpressure();
        int base, pb;
        logic [127:0] exp, held;
        do_reset();
        base = cap_n;
        pb   = pop_total;
        for (int i = 0; i < 12; i++) push_word(32'h100 + 32'(i));
        enable = 1'b1;
        cycles(10);
        #1;
        n_checks++;
        if (pop_total - pb != 8 || fifo_re !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall: pops=%0d fifo_re=%b required 8/0", pop_total - pb, fifo_re);
        end
        exp = 128'h00000103_00000102_00000101_00000100;
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== exp) begin
            n_fail++;
            $display("FAIL bp_hold: valid=%b data=%h required 1 %h", m_valid, m_data, exp);
        end
        held = m_data;
        cycles(1);
        #1;
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== exp || m_keep !== 4'hF) begin
            n_fail++;
            $display("FAIL bp_stable: valid=%b data=%h keep=%h required 1 %h F", m_valid, m_data, m_keep, held);
        end
        m_ready = 1'b1;
        cycles(12);
        n_checks++;
        if (cap_n - base != 3) begin
            n_fail++;
            $display("FAIL bp_beats: got %0d required 3", cap_n - base);
        end else begin
            for (int b = 0; b < 3; b++) begin
                for (int j = 0; j < 4; j++) exp[32*j +: 32] = 32'h100 + 32'(4*b + j);
                n_checks++;
                if (cap_data[base+b] !== exp) begin
                    n_fail++;
                    $display("FAIL bp_data%0d: got %h required %h", b, cap_data[base+b], exp);
                end
            end
        end
        $display("test_backpressure done");
    endtask

    task automatic test_flush();
        int base, pb;
        logic [127:0] exp;
        do_reset();
        base = cap_n;
        pb   = pop_total;
        m_ready = 1'b1;
        push_word(32'hA); push_word(32'hB); push_word(32'hC);
        enable = 1'b1;
        cycles(5);
        push_word(32'hD); push_word(32'hE);
        flush_req = 1'b1;
        #1;
        n_checks++;
        if (fifo_re !== 1'b0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_req_cycle: fifo_re=%b m_valid=%b required 0/0", fifo_re, m_valid);
        end
        @(negedge user_clk);
        flush_req = 1'b0;
        #1;
        exp = 128'h00000000_0000000C_0000000B_0000000A;
        n_checks++;
        if (fifo_re !== 1'b0 || flush_done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_pend_block: fifo_re=%b flush_done=%b required 0/0", fifo_re, flush_done);
        end
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== exp || m_keep !== 4'b0111 || m_last !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_beat: valid=%b data=%h keep=%b last=%b required 1 %h 0111 1",
                     m_valid, m_data, m_keep, m_last, exp);
        end
        @(negedge user_clk);
        #1;
        n_checks++;
        if (flush_done !== 1'b1 || pop_total - pb != 3) begin
            n_fail++;
            $display("FAIL flush_done_pulse: flush_done=%b pops=%0d required 1/3", flush_done, pop_total - pb);
        end
        @(negedge user_clk);
        #1;
        n_checks++;
        if (flush_done !== 1'b0 || cap_n - base < 1 || fd_cyc != cap_cyc[base] + 1) begin
            n_fail++;
            $display("FAIL flush_done_timing: flush_done=%b fd_cyc=%0d required 0 and %0d",
                     flush_done, fd_cyc, cap_cyc[base] + 1);
        end
        $display("test_flush done");
    endtask

    task automatic test_timeout();
        int k, fdb;
        logic found;
        logic [127:0] exp;
        do_reset();
        fdb = fd_cnt;
        m_ready = 1'b1;
        push_word(32'h11); push_word(32'h22);
        enable = 1'b1;
        k = 0;
        found = 1'b0;
        while (k < 40 && !found) begin
            #1;
            if (m_valid) found = 1'b1;
            else begin
                @(negedge user_clk);
                k++;
            end
        end
        n_checks++;
        if (!found || k != 19) begin
            n_fail++;
            $display("FAIL timeout_latency: found=%b cycles=%0d required 1/19", found, k);
        end
        exp = 128'h00000000_00000000_00000022_00000011;
        n_checks++;
        if (m_data !== exp || m_keep !== 4'b0011 || m_last !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_beat: data=%h keep=%b last=%b required %h 0011 1", m_data, m_keep, m_last, exp);
        end
        cycles(4);
        n_checks++;
        if (fd_cnt != fdb) begin
            n_fail++;
            $display("FAIL timeout_no_done: flush_done pulses=%0d required 0", fd_cnt - fdb);
        end
        $display("test_timeout done");
    endtask

    task automatic test_empty_flush();
        int base;
        do_reset();
        base = cap_n;
        enable  = 1'b1;
        m_ready = 1'b1;
        cycles(2);
        flush_req = 1'b1;
        #1;
        n_checks++;
        if (fifo_re !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_fifo_re: got %b required 0", fifo_re);
        end
        @(negedge user_clk);
        flush_req = 1'b0;
        #1;
        n_checks++;
        if (flush_done !== 1'b1 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_flush_done: flush_done=%b m_valid=%b required 1/0", flush_done, m_valid);
        end
        @(negedge user_clk);
        #1;
        n_checks++;
        if (flush_done !== 1'b0 || cap_n != base) begin
            n_fail++;
            $display("FAIL empty_flush_after: flush_done=%b beats=%0d required 0/0", flush_done, cap_n - base);
        end
        $display("test_empty_flush done");
    endtask

    task automatic test_reset_mid();
        int base;
        logic [127:0] exp;
        do_reset();
        for (int i = 0; i < 6; i++) push_word(32'h40 + 32'(i));
        enable = 1'b1;
        cycles(6);
        #1;
        n_checks++;
        if (m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: m_valid=%b required 1", m_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({m_valid, m_keep, m_last, fifo_re, flush_done} !== 8'd0 || m_data !== 128'd0 || beat_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: ctrl=%b data=%h beat_cnt=%0d required all zero",
                     {m_valid, m_keep, m_last, fifo_re, flush_done}, m_data, beat_cnt);
        end
        @(negedge user_clk);
        wr_ptr = rd_ptr;
        @(negedge user_clk);
        reset_n = 1'b1;
        cycles(2);
        base = cap_n;
        for (int i = 0; i < 4; i++) push_word(32'h50 + 32'(i));
        m_ready = 1'b1;
        cycles(8);
        exp = 128'h00000053_00000052_00000051_00000050;
        n_checks++;
        if (cap_n - base != 1 || cap_data[base] !== exp || cap_keep[base] !== 4'hF || cap_last[base] !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_clean_beat: beats=%0d data=%h keep=%h last=%b required 1 %h F 0",
                     cap_n - base, cap_data[base], cap_keep[base], cap_last[base], exp);
        end
        n_checks++;
        if (beat_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL rstmid_beat_cnt: got %0d required 1", beat_cnt);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        flush_req = 1'b0;
        m_ready   = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_timeout();
        test_empty_flush();
        test_reset_mid();
        n_checks++;
        if (re_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL fifo_re_when_empty: flag=%b required 0", re_empty);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
